immediate_decode_stage: RTL and testbench

Registered, flow-controlled successor to the combinational immediate extender for RV32/RV64 decode. Each beat takes a 32-bit instruction and its PC and produces the sign/zero-extended immediate, a format code, a PC-relative target and an illegal-opcode flag. A two-entry skid buffer sits between fetch and the decode/issue stage, so that stage can apply backpressure without a combinational ready path.

---
 rtl/immediate_decode_stage.sv | 168 ++++++++++++++++
 tb/tb_immediate_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/immediate_decode_stage.sv
// Registered RV32/RV64 immediate decoder behind a two-entry skid buffer (main M, skid K).
// Optional CSR-immediate decode is enabled by defining IMMEDIATE_ZICSR_EN.
module immediate_decode_stage #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instruction,
    input  logic [N-1:0] in_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instruction,
    output logic [N-1:0] out_immediate,
    output logic [N-1:0] out_target,
    output logic [2:0]   out_format,
    output logic         out_illegal
);

    if (N != 32 && N != 64) begin : g_bad_width
        $error("immediate_decode_stage: N must be 32 or 64");
    end

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ALUIW  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_CSR   = 3'd7;

    typedef struct packed {
        logic [31:0]  instr;
        logic [N-1:0] imm;
        logic [N-1:0] target;
        logic [2:0]   fmt;
        logic         illegal;
    } beat_t;

    beat_t      d_beat, m_beat, k_beat;
    logic       m_valid, k_valid;
    logic [6:0] op;
    logic [2:0] f3;
    logic       is_shift;

    assign op       = in_instruction[6:0];
    assign f3       = in_instruction[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        d_beat.instr   = in_instruction;
        d_beat.imm     = '0;
        d_beat.fmt     = FMT_NONE;
        d_beat.illegal = 1'b0;
        case (op)
            OP_ALUI: begin
                if (is_shift) begin
                    d_beat.fmt = FMT_SHAMT;
                    d_beat.imm = (N == 64) ? N'(in_instruction[25:20]) : N'(in_instruction[24:20]);
                end else begin
                    d_beat.fmt = FMT_I;
                    d_beat.imm = N'($signed(in_instruction[31:20]));
                end
            end
            OP_LOAD, OP_JALR: begin
                d_beat.fmt = FMT_I;
                d_beat.imm = N'($signed(in_instruction[31:20]));
            end
            OP_ALUIW: begin
                if (N != 64) begin
                    d_beat.illegal = 1'b1;
                end else if (is_shift) begin
                    d_beat.fmt = FMT_SHAMT;
                    d_beat.imm = N'(in_instruction[24:20]);
                end else begin
                    d_beat.fmt = FMT_I;
                    d_beat.imm = N'($signed(in_instruction[31:20]));
                end
            end
            OP_STORE: begin
                d_beat.fmt = FMT_S;
                d_beat.imm = N'($signed({in_instruction[31:25], in_instruction[11:7]}));
            end
            OP_BRANCH: begin
                d_beat.fmt = FMT_B;
                d_beat.imm = N'($signed({in_instruction[31], in_instruction[7],
                                         in_instruction[30:25], in_instruction[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                d_beat.fmt = FMT_U;
                d_beat.imm = N'($signed({in_instruction[31:12], 12'b0}));
            end
            OP_JAL: begin
                d_beat.fmt = FMT_J;
                d_beat.imm = N'($signed({in_instruction[31], in_instruction[19:12],
                                         in_instruction[20], in_instruction[30:21], 1'b0}));
            end
            OP_R: ;
            OP_RW: d_beat.illegal = (N != 64);
            OP_SYSTEM: begin
`ifdef IMMEDIATE_ZICSR_EN
                if (f3[2] && (f3[1:0] != 2'b00)) begin
                    d_beat.fmt = FMT_CSR;
                    d_beat.imm = N'(in_instruction[19:15]);
                end
`endif
            end
            default: d_beat.illegal = 1'b1;
        endcase
        // Only branches, jal and auipc produce a PC-relative target; all else is the fall-through PC.
        if (d_beat.fmt == FMT_B || d_beat.fmt == FMT_J || op == OP_AUIPC)
            d_beat.target = in_pc + d_beat.imm;
        else
            d_beat.target = in_pc + N'(4);
    end

    // in_ready is !k_valid, so an accept can only coincide with an empty skid register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
            m_beat  <= '0;
            k_beat  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
        end else if (!m_valid || out_ready) begin
            if (k_valid) begin
                m_beat  <= k_beat;
                m_valid <= 1'b1;
                k_valid <= 1'b0;
            end else if (in_valid) begin
                m_beat  <= d_beat;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_valid && !k_valid) begin
            k_beat  <= d_beat;
            k_valid <= 1'b1;
        end
    end

    assign in_ready        = !k_valid;
    assign out_valid       = m_valid;
    assign out_instruction = m_beat.instr;
    assign out_immediate   = m_beat.imm;
    assign out_target      = m_beat.target;
    assign out_format      = m_beat.fmt;
    assign out_illegal     = m_beat.illegal;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Directed bench for immediate_decode_stage: decode vectors at N=32 and N=64, skid-buffer
// backpressure, flush and asynchronous reset. CSR expectations follow IMMEDIATE_ZICSR_EN.
module tb_immediate_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instruction;
    logic [31:0] out_immediate;
    logic [31:0] out_target;
    logic [2:0]  out_format;
    logic        out_illegal;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] in_instruction64 = '0;
    logic [63:0] in_pc64 = '0;
    logic        out_valid64;
    logic [31:0] out_instruction64;
    logic [63:0] out_immediate64;
    logic [63:0] out_target64;
    logic [2:0]  out_format64;
    logic        out_illegal64;

    int vectors = 0;
    int miscompares = 0;

    immediate_decode_stage #(.N(32)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_immediate(out_immediate),
        .out_target(out_target), .out_format(out_format), .out_illegal(out_illegal)
    );

    immediate_decode_stage #(.N(64)) dut64 (
        .clock(clock), .reset_n(reset_n), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_instruction(in_instruction64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(1'b1),
        .out_instruction(out_instruction64), .out_immediate(out_immediate64),
        .out_target(out_target64), .out_format(out_format64), .out_illegal(out_illegal64)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc          = pc;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] instr, input logic [31:0] imm,
                               input logic [31:0] target, input logic [2:0] fmt, input logic ill);
        check({tag, ".valid"},  64'(out_valid), 64'(1));
        check({tag, ".instr"},  64'(out_instruction), 64'(instr));
        check({tag, ".imm"},    64'(out_immediate), 64'(imm));
        check({tag, ".target"}, 64'(out_target), 64'(target));
        check({tag, ".format"}, 64'(out_format), 64'(fmt));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    task automatic expect_beat64(input string tag, input logic [63:0] imm, input logic [63:0] target,
                                 input logic [2:0] fmt, input logic ill);
        check({tag, ".valid"},   64'(out_valid64), 64'(1));
        check({tag, ".imm"},     out_immediate64, imm);
        check({tag, ".target"},  out_target64, target);
        check({tag, ".format"},  64'(out_format64), 64'(fmt));
        check({tag, ".illegal"}, 64'(out_illegal64), 64'(ill));
    endtask

    initial begin
        #2;
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.in_ready",  64'(in_ready), 64'(1));
        check("reset.imm",       64'(out_immediate), 64'(0));
        check("reset.target",    64'(out_target), 64'(0));
        check("reset.instr",     64'(out_instruction), 64'(0));
        check("reset.format",    64'(out_format), 64'(0));
        check("reset.illegal",   64'(out_illegal), 64'(0));
        #10 reset_n = 1'b1;
        tick();

        // Back-to-back decode at full throughput, one beat per cycle
        drive(32'hFFF00093, 32'h100);   tick(); expect_beat("addi", 32'hFFF00093, 32'hFFFFFFFF, 32'h104, 3'd1, 1'b0);
        drive(32'h0080006F, 32'h1000);  tick(); expect_beat("jal", 32'h0080006F, 32'h8, 32'h1008, 3'd5, 1'b0);
        drive(32'hFE000EE3, 32'h2000);  tick(); expect_beat("beq", 32'hFE000EE3, 32'hFFFFFFFC, 32'h1FFC, 3'd3, 1'b0);
        drive(32'h0010009B, 32'h3000);  tick(); expect_beat("addiw32", 32'h0010009B, 32'h0, 32'h3004, 3'd0, 1'b1);
        drive(32'hFE112E23, 32'h40);    tick(); expect_beat("sw", 32'hFE112E23, 32'hFFFFFFFC, 32'h44, 3'd2, 1'b0);
        drive(32'h00509093, 32'h50);    tick(); expect_beat("slli", 32'h00509093, 32'h5, 32'h54, 3'd6, 1'b0);
        drive(32'h41F0D093, 32'h60);    tick(); expect_beat("srai", 32'h41F0D093, 32'h1F, 32'h64, 3'd6, 1'b0);
        drive(32'h00001097, 32'h4000);  tick(); expect_beat("auipc", 32'h00001097, 32'h1000, 32'h5000, 3'd4, 1'b0);
        drive(32'hFFFFF097, 32'h2000);  tick(); expect_beat("auipc_wrap", 32'hFFFFF097, 32'hFFFFF000, 32'h1000, 3'd4, 1'b0);
        drive(32'h800000B7, 32'h70);    tick(); expect_beat("lui32", 32'h800000B7, 32'h80000000, 32'h74, 3'd4, 1'b0);
        drive(32'h002081B3, 32'h80);    tick(); expect_beat("add", 32'h002081B3, 32'h0, 32'h84, 3'd0, 1'b0);
        drive(32'h0000007F, 32'h90);    tick(); expect_beat("bad_op", 32'h0000007F, 32'h0, 32'h94, 3'd0, 1'b1);
        drive(32'hFFC08067, 32'hA0);    tick(); expect_beat("jalr", 32'hFFC08067, 32'hFFFFFFFC, 32'hA4, 3'd1, 1'b0);
`ifdef IMMEDIATE_ZICSR_EN
        drive(32'h300FD073, 32'hB0);    tick(); expect_beat("csrrwi", 32'h300FD073, 32'h1F, 32'hB4, 3'd7, 1'b0);
`else
        drive(32'h300FD073, 32'hB0);    tick(); expect_beat("csrrwi", 32'h300FD073, 32'h0, 32'hB4, 3'd0, 1'b0);
`endif
        drive(32'h00000073, 32'hC0);    tick(); expect_beat("ecall", 32'h00000073, 32'h0, 32'hC4, 3'd0, 1'b0);
        in_valid = 1'b0;                tick(); check("idle.out_valid", 64'(out_valid), 64'(0));

        // Backpressure: A, B, C offered with out_ready low for three cycles
        out_ready = 1'b0;
        drive(32'h00100093, 32'h0);     tick();
        check("bp1.in_ready", 64'(in_ready), 64'(1));
        check("bp1.instr", 64'(out_instruction), 64'(32'h00100093));
        drive(32'h00200093, 32'h4);     tick();
        check("bp2.in_ready", 64'(in_ready), 64'(0));
        check("bp2.instr", 64'(out_instruction), 64'(32'h00100093));
        drive(32'h00300093, 32'h8);     tick();
        check("bp3.in_ready", 64'(in_ready), 64'(0));
        check("bp3.valid", 64'(out_valid), 64'(1));
        check("bp3.instr", 64'(out_instruction), 64'(32'h00100093));
        out_ready = 1'b1;               tick();
        expect_beat("bp_b", 32'h00200093, 32'h2, 32'h8, 3'd1, 1'b0);
        check("bp_b.in_ready", 64'(in_ready), 64'(1));
        tick();
        expect_beat("bp_c", 32'h00300093, 32'h3, 32'hC, 3'd1, 1'b0);
        in_valid = 1'b0;                tick();
        check("bp_end.valid", 64'(out_valid), 64'(0));

        // Flush with M and K full; the beat offered during flush is dropped
        out_ready = 1'b0;
        drive(32'h00100093, 32'h0);     tick();
        drive(32'h00200093, 32'h4);     tick();
        check("fl_full.in_ready", 64'(in_ready), 64'(0));
        flush = 1'b1;
        drive(32'h00300093, 32'h8);     tick();
        check("flush.out_valid", 64'(out_valid), 64'(0));
        check("flush.in_ready", 64'(in_ready), 64'(1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        check("flush_drop.out_valid", 64'(out_valid), 64'(0));

        // Asynchronous reset with both registers full, checked before the next edge
        out_ready = 1'b0;
        drive(32'hFFF00093, 32'h100);   tick();
        drive(32'h0080006F, 32'h1000);  tick();
        check("pre_rst.in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'(0));
        check("arst.in_ready",  64'(in_ready), 64'(1));
        check("arst.imm",       64'(out_immediate), 64'(0));
        check("arst.target",    64'(out_target), 64'(0));
        check("arst.instr",     64'(out_instruction), 64'(0));
        check("arst.format",    64'(out_format), 64'(0));
        check("arst.illegal",   64'(out_illegal), 64'(0));
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst.out_valid", 64'(out_valid), 64'(0));

        // N=64 instance
        in_valid64 = 1'b1;
        in_instruction64 = 32'h800000B7; in_pc64 = 64'h1000; tick();
        expect_beat64("lui64", 64'hFFFFFFFF80000000, 64'h1004, 3'd4, 1'b0);
        in_instruction64 = 32'h0010009B; in_pc64 = 64'h2000; tick();
        expect_beat64("addiw64", 64'h1, 64'h2004, 3'd1, 1'b0);
        in_instruction64 = 32'h03F09093; in_pc64 = 64'h3000; tick();
        expect_beat64("slli64", 64'd63, 64'h3004, 3'd6, 1'b0);
        in_instruction64 = 32'h0030D09B; in_pc64 = 64'h4000; tick();
        expect_beat64("srliw64", 64'd3, 64'h4004, 3'd6, 1'b0);
        in_instruction64 = 32'h002081BB; in_pc64 = 64'h5000; tick();
        expect_beat64("addw64", 64'h0, 64'h5004, 3'd0, 1'b0);
        in_instruction64 = 32'hFE000EE3; in_pc64 = 64'h0; tick();
        expect_beat64("beq64_wrap", 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        in_valid64 = 1'b0; tick();
        check("idle64.out_valid", 64'(out_valid64), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
